// File: rtl/mtr_drv_pkg.sv
// Purpose: shared types, constants and helpers for the motor-drive back end.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mtr_drv_pkg;

   localparam int PWM_W = 11;

   typedef logic [PWM_W-1:0] duty_t;

   // Duty that leaves the bridge balanced (motor stopped).
   localparam duty_t MID_DUTY        = 11'h400;
   // Last count of a PWM period; duty reloads on this count.
   localparam duty_t PERIOD_END      = 11'h7FF;
   // Default dead time between one side falling and the other rising.
   localparam duty_t NONOVERLAP_DFLT = 11'h020;
   // Largest duty change allowed per period when slew limiting is built in.
   localparam duty_t SLEW_STEP       = 11'd64;

   // Signed speed -> offset-binary duty: adding 0x400 modulo 2048 only
   // flips the sign bit, so no adder is needed.
   function automatic duty_t spd2duty(input logic [PWM_W-1:0] spd);
      return {~spd[PWM_W-1], spd[PWM_W-2:0]};
   endfunction

   // Move cur toward tgt by at most step, landing exactly on tgt when close.
   function automatic duty_t slew_toward(input duty_t cur, input duty_t tgt,
                                         input duty_t step);
      duty_t diff;
      if (tgt > cur) begin
         diff = tgt - cur;
         return (diff > step) ? duty_t'(cur + step) : tgt;
      end else begin
         diff = cur - tgt;
         return (diff > step) ? duty_t'(cur - step) : tgt;
      end
   endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// Purpose: speed command in / H-bridge gate drive out, bundled for mtr_drv.
// Latency: n/a (wires only).
// Backpressure: none; speeds are level signals sampled once per PWM period.
interface mtr_drv_if;

   logic [10:0] lft_spd;
   logic [10:0] rght_spd;
   logic        lftPWM1;
   logic        lftPWM2;
   logic        rghtPWM1;
   logic        rghtPWM2;

   // Speed source side (PID block).
   modport master (
      output lft_spd,
      output rght_spd,
      input  lftPWM1,
      input  lftPWM2,
      input  rghtPWM1,
      input  rghtPWM2
   );

   // Motor driver side.
   modport slave (
      input  lft_spd,
      input  rght_spd,
      output lftPWM1,
      output lftPWM2,
      output rghtPWM1,
      output rghtPWM2
   );

endinterface

// File: rtl/pwm11.sv
// Purpose: one complementary PWM pair with dead time, driven from a shared counter.
// Latency: outputs are flops, 1 clk after the counter value they reflect.
// Backpressure: none; free-running.
module pwm11
   import mtr_drv_pkg::*;
#(
   parameter duty_t NONOVERLAP = NONOVERLAP_DFLT
) (
   input  logic  clk,
   input  logic  rst_n,
   input  duty_t cnt,
   input  duty_t duty_act,
   output logic  PWM1,
   output logic  PWM2
);

   // Low side turns on only after the high side has been off for NONOVERLAP
   // clocks. Kept one bit wider so a large duty pushes the threshold past the
   // end of the period (low side stays off) instead of wrapping.
   logic [PWM_W:0] lo_on_thr;

   assign lo_on_thr = {1'b0, duty_act} + {1'b0, NONOVERLAP};

   // High side on from NONOVERLAP up to duty; low side on from duty+NONOVERLAP
   // to period end. The wrap gap (low falls at 0, high rises at NONOVERLAP)
   // gives the dead time on the other handover.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PWM1 <= 1'b0;
         PWM2 <= 1'b0;
      end else begin
         PWM1 <= (cnt >= NONOVERLAP) && (cnt < duty_act);
         PWM2 <= ({1'b0, cnt} >= lo_on_thr);
      end
   end

endmodule

// File: rtl/mtr_drv.sv
// Purpose: speed -> double-buffered duty -> two dead-time PWM pairs (MTR_DRV_SLEW_EN adds slew limit).
// Latency: speed sampled at cnt==0x7FF, used from cnt==0; PWM outputs 1 clk after cnt.
// Backpressure: none; speeds are sampled once per 2048-clk period, changes in between ignored.
module mtr_drv
   import mtr_drv_pkg::*;
#(
   parameter duty_t NONOVERLAP = NONOVERLAP_DFLT
) (
   input  logic        clk,
   input  logic        rst_n,
   mtr_drv_if.slave    bus
);

   duty_t cnt;
   duty_t lft_duty_act;
   duty_t rght_duty_act;
   duty_t lft_duty_nxt;
   duty_t rght_duty_nxt;
   logic  period_end;

   logic  lft_pwm1;
   logic  lft_pwm2;
   logic  rght_pwm1;
   logic  rght_pwm2;

   assign period_end = (cnt == PERIOD_END);

   // Free-running period counter shared by both channels; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 11'd1;
      end
   end

   // Duty that will take effect next period, from the live speed commands.
   always_comb begin
      lft_duty_nxt  = MID_DUTY;
      rght_duty_nxt = MID_DUTY;
`ifdef MTR_DRV_SLEW_EN
      lft_duty_nxt  = slew_toward(lft_duty_act,  spd2duty(bus.lft_spd),  SLEW_STEP);
      rght_duty_nxt = slew_toward(rght_duty_act, spd2duty(bus.rght_spd), SLEW_STEP);
`else
      lft_duty_nxt  = spd2duty(bus.lft_spd);
      rght_duty_nxt = spd2duty(bus.rght_spd);
`endif
   end

   // Active duty reloads only on the last count so a period never sees two duties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_duty_act  <= MID_DUTY;
         rght_duty_act <= MID_DUTY;
      end else if (period_end) begin
         lft_duty_act  <= lft_duty_nxt;
         rght_duty_act <= rght_duty_nxt;
      end
   end

   pwm11 #(.NONOVERLAP(NONOVERLAP)) u_pwm_lft (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt      (cnt),
      .duty_act (lft_duty_act),
      .PWM1     (lft_pwm1),
      .PWM2     (lft_pwm2)
   );

   pwm11 #(.NONOVERLAP(NONOVERLAP)) u_pwm_rght (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt      (cnt),
      .duty_act (rght_duty_act),
      .PWM1     (rght_pwm1),
      .PWM2     (rght_pwm2)
   );

   assign bus.lftPWM1  = lft_pwm1;
   assign bus.lftPWM2  = lft_pwm2;
   assign bus.rghtPWM1 = rght_pwm1;
   assign bus.rghtPWM2 = rght_pwm2;

endmodule

// File: tb/tb_mtr_drv.sv
// Purpose: self-checking bench for mtr_drv; per-cycle model compare plus per-period literal counts.
// Latency: n/a.
// Backpressure: n/a.
module tb_mtr_drv;

   logic clk;
   logic rst_n;

   mtr_drv_if bus();

   mtr_drv dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // ---------------- behavioural model ----------------
   // Period position and per-period duty kept as plain integers; the duty
   // for a period is the offset speed (-1024..1023 -> 0..2047).
   int       m_pos;
   int       m_lduty;
   int       m_rduty;
   logic [3:0] m_exp;   // {r2, r1, l2, l1}

   function automatic int next_duty(input int cur, input int tgt);
      int d;
`ifdef MTR_DRV_SLEW_EN
      d = tgt - cur;
      if (d > 64)       return cur + 64;
      else if (d < -64) return cur - 64;
      else              return tgt;
`else
      d = cur;
      return tgt + (d - cur);
`endif
   endfunction

   // Output after this edge reflects the position the counter held before it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos   = 0;
         m_lduty = 1024;
         m_rduty = 1024;
         m_exp   = 4'b0000;
      end else begin
         m_exp[0] = (m_pos >= 32) && (m_pos < m_lduty);
         m_exp[1] = (m_pos >= m_lduty + 32);
         m_exp[2] = (m_pos >= 32) && (m_pos < m_rduty);
         m_exp[3] = (m_pos >= m_rduty + 32);
         if (m_pos == 2047) begin
            m_lduty = next_duty(m_lduty, $signed(bus.lft_spd) + 1024);
            m_rduty = next_duty(m_rduty, $signed(bus.rght_spd) + 1024);
         end
         m_pos = (m_pos + 1) % 2048;
      end
   end

   // Every out-of-reset cycle: outputs match the model and no pair overlaps.
   always @(negedge clk) begin
      logic [3:0] act;
      if (rst_n === 1'b1) begin
         act = {bus.rghtPWM2, bus.rghtPWM1, bus.lftPWM2, bus.lftPWM1};
         n_cmp++;
         if (act !== m_exp) begin
            n_err++;
            $display("FAIL pwm_cycle t=%0t: got %b expected %b", $time, act, m_exp);
         end
         n_cmp++;
         if ((act[0] & act[1]) | (act[2] & act[3])) begin
            n_err++;
            $display("FAIL overlap t=%0t: got %b expected no pair both high", $time, act);
         end
      end
   end

   // ---------------- directed stimulus + literal checks ----------------
   int p_hi[4];
   int p_first[4];
   int p_last[4];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One full period, aligned so sample i reflects counter value i.
   task automatic run_period(input int l_at, input logic [10:0] nl,
                             input int r_at, input logic [10:0] nr);
      logic [3:0] pw;
      for (int j = 0; j < 4; j++) begin
         p_hi[j] = 0; p_first[j] = -1; p_last[j] = -1;
      end
      for (int i = 0; i < 2048; i++) begin
         @(negedge clk);
         pw = {bus.rghtPWM2, bus.rghtPWM1, bus.lftPWM2, bus.lftPWM1};
         for (int j = 0; j < 4; j++) begin
            if (pw[j]) begin
               p_hi[j]++;
               if (p_first[j] < 0) p_first[j] = i;
               p_last[j] = i;
            end
         end
         if (i == l_at) bus.lft_spd  = nl;
         if (i == r_at) bus.rght_spd = nr;
      end
   endtask

   task automatic chk_hi(input string tag, input int l1, input int l2,
                         input int r1, input int r2);
      chk({tag, "_l1_hi"}, p_hi[0], l1);
      chk({tag, "_l2_hi"}, p_hi[1], l2);
      chk({tag, "_r1_hi"}, p_hi[2], r1);
      chk({tag, "_r2_hi"}, p_hi[3], r2);
   endtask

   initial begin
      logic [3:0] outs;
      rst_n        = 1'b0;
      bus.lft_spd  = 11'h000;
      bus.rght_spd = 11'h000;
      repeat (3) @(negedge clk);
      outs = {bus.rghtPWM2, bus.rghtPWM1, bus.lftPWM2, bus.lftPWM1};
      chk("reset_outputs", int'(outs), 0);
      rst_n = 1'b1;

`ifdef MTR_DRV_SLEW_EN
      // Left steps 0 -> full forward; duty climbs 64 per period, high time = duty-32.
      run_period(10, 11'h3FF, -1, 11'h000);
      chk_hi("slew_p0", 992, 992, 992, 992);
      for (int k = 1; k <= 17; k++) begin
         run_period(-1, 11'h3FF, -1, 11'h000);
         chk($sformatf("slew_p%0d_l1_hi", k), p_hi[0], (k <= 15) ? (992 + 64 * k) : 2015);
         chk($sformatf("slew_p%0d_r1_hi", k), p_hi[2], 992);
      end
`else
      // A: both stopped; mid-period changes must not take effect yet.
      run_period(100, 11'h3FF, 500, 11'h100);
      chk_hi("stop", 992, 992, 992, 992);
      chk("stop_l1_first", p_first[0], 32);
      chk("stop_l1_last",  p_last[0],  1023);
      chk("stop_l2_first", p_first[1], 1056);
      chk("stop_l2_last",  p_last[1],  2047);

      // B: left full forward, right duty 0x500.
      run_period(50, 11'h400, -1, 11'h000);
      chk_hi("fwd", 2015, 0, 1248, 736);
      chk("fwd_r1_first", p_first[2], 32);
      chk("fwd_r1_last",  p_last[2],  1279);
      chk("fwd_r2_first", p_first[3], 1312);

      // C: left full reverse (duty 0).
      run_period(50, 11'h420, 60, 11'h3E0);
      chk_hi("rev", 0, 2016, 1248, 736);
      chk("rev_l2_first", p_first[1], 32);

      // D: left duty == dead time, right duty+dead time just past period end.
      run_period(-1, 11'h000, -1, 11'h000);
      chk_hi("edge", 0, 1984, 1984, 0);

      // E: async reset mid-period while right high side is on.
      for (int i = 0; i <= 700; i++) @(negedge clk);
      chk("pre_rst_r1", int'(bus.rghtPWM1), 1);
      #2 rst_n = 1'b0;
      #1;
      outs = {bus.rghtPWM2, bus.rghtPWM1, bus.lftPWM2, bus.lftPWM1};
      chk("async_rst_outputs", int'(outs), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // F: duty back at stop regardless of held speed inputs.
      run_period(-1, 11'h000, -1, 11'h000);
      chk_hi("post_rst", 992, 992, 992, 992);
      chk("post_rst_l1_first", p_first[0], 32);

      // G: held inputs now loaded.
      run_period(-1, 11'h000, -1, 11'h000);
      chk_hi("reload", 0, 1984, 1984, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
